// File: rtl/reg_dump_reader.sv
// Walks the CPU register file through one combinational read port and streams each word out
// over valid/ready. Optional trailing XOR checksum beat under `REG_DUMP_CHECKSUM_EN.
module reg_dump_reader #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [ADDR_W:0]   out_idx_o,
  output logic              out_last_o
);

  localparam logic [ADDR_W:0] LastRegIdx = (ADDR_W+1)'(NUM_REGS - 1);

`ifdef REG_DUMP_CHECKSUM_EN
  localparam logic [ADDR_W:0] CsumIdx = (ADDR_W+1)'(NUM_REGS);

  typedef enum logic [2:0] {StIdle, StRead, StHold, StDone, StCsum} state_e;
`else
  typedef enum logic [2:0] {StIdle, StRead, StHold, StDone} state_e;
`endif

  state_e              state_q, state_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W:0]     oidx_q, oidx_d;
  logic                last_q, last_d;
  logic                valid_q, valid_d;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0]   csum_q, csum_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    oidx_d  = oidx_q;
    last_d  = last_q;
    valid_d = valid_q;
`ifdef REG_DUMP_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    busy_o  = 1'b0;
    done_o  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          idx_d   = '0;
          addr_d  = '0;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
          state_d = StRead;
        end
      end
      StRead: begin
        busy_o  = 1'b1;
        data_d  = rd_data_i;
        oidx_d  = idx_q;
        valid_d = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
        last_d  = 1'b0;
        csum_d  = csum_q ^ rd_data_i;
`else
        last_d  = (idx_q == LastRegIdx);
`endif
        state_d = StHold;
      end
      StHold: begin
        busy_o = 1'b1;
        if (out_ready_i) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            state_d = StDone;
`ifdef REG_DUMP_CHECKSUM_EN
          end else if (idx_q == LastRegIdx) begin
            state_d = StCsum;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            addr_d  = ADDR_W'(idx_q + 1'b1);
            state_d = StRead;
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      StCsum: begin
        // Read port address is left on the last register.
        busy_o  = 1'b1;
        idx_d   = CsumIdx;
        data_d  = csum_q;
        oidx_d  = CsumIdx;
        last_d  = 1'b1;
        valid_d = 1'b1;
        state_d = StHold;
      end
`endif
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      oidx_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      oidx_q  <= oidx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign rd_addr_o   = addr_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_idx_o   = oidx_q;
  assign out_last_o  = last_q;

endmodule
